// File: rtl/reg_file_display_ctrl_pkg.sv
// Shared types, constants and the hex-to-segment decoder for the register-file
// display controller. No ports; imported by the interface users and the top.
package reg_file_pkg;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    // Active-low segments {g..a}; all ones turns every segment off.
    localparam logic [6:0] SSEG_BLANK = 7'h7F;

    // The scan counter exposes two digit-select bits, so at most four digits.
    localparam int MAX_DIGITS = 4;

    function automatic int digit_count(input int bits);
        return bits / 4;
    endfunction

    function automatic bit widths_ok(input int bits, input int an_w);
        return (bits % 4 == 0) && (bits / 4 >= 1) &&
               (bits / 4 <= MAX_DIGITS) && (an_w >= bits / 4);
    endfunction

    function automatic logic [6:0] hex2sseg(input logic [3:0] hex);
        logic [6:0] seg;
        unique case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/reg_file_display_ctrl_if.sv
// Board-side bundle: switch/button inputs toward the controller and the
// multiplexed 7-seg outputs back. master = board/stimulus, slave = controller.
interface reg_file_display_ctrl_if #(
    parameter int ADDR_W = 7,
    parameter int BITS   = 8,
    parameter int AN_W   = 8
);
    logic [ADDR_W:0]   addr_in;
    logic              we_btn;
    logic              clr_btn;
    logic [BITS-1:0]   data_w;
    logic [6:0]        sseg;
    logic [AN_W-1:0]   an;
    logic              busy;

    modport master (
        output addr_in, we_btn, clr_btn, data_w,
        input  sseg, an, busy
    );

    modport slave (
        input  addr_in, we_btn, clr_btn, data_w,
        output sseg, an, busy
    );
endinterface

// File: rtl/reg_file_display_ctrl_debounce.sv
// Button conditioner: emits one 1-cycle pulse after `in` is high for DB_CYCLES
// consecutive clocks, then stays quiet until `in` drops. Ports: clk, reset, in, out.
module debounce_pulse #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          fired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            fired <= 1'b0;
            out   <= 1'b0;
        end else if (!in) begin
            cnt   <= '0;
            fired <= 1'b0;
            out   <= 1'b0;
        end else if (fired) begin
            out <= 1'b0;
        end else if (cnt == CW'(DB_CYCLES - 1)) begin
            // This is the DB_CYCLES-th consecutive high sample.
            cnt   <= '0;
            fired <= 1'b1;
            out   <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
            out <= 1'b0;
        end
    end
endmodule

// File: rtl/reg_file_display_ctrl.sv
// Register-file front end: latches read/write addresses from one switch bus,
// writes on a debounced button, clears the array with a hardware sweep and
// scans the read word onto multiplexed 7-seg. Ports: clk, reset, bus (slave).
module reg_file_display_ctrl
    import reg_file_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int BITS      = 8,
    parameter int AN_W      = 8,
    parameter int DB_CYCLES = 1_000_000,
    parameter int REFRESH_W = 18
) (
    input logic                      clk,
    input logic                      reset,
    reg_file_display_ctrl_if.slave   bus
);
    localparam int DIGITS = digit_count(BITS);
    localparam int DEPTH  = 1 << ADDR_W;
    // Scan counter wraps once every populated digit has had its slot.
    localparam logic [REFRESH_W:0] SCAN_LIMIT =
        (REFRESH_W + 1)'(DIGITS) << (REFRESH_W - 2);

    if (!widths_ok(BITS, AN_W) || REFRESH_W < 2) begin : g_bad_params
        $error("reg_file_display_ctrl: unsupported BITS/AN_W/REFRESH_W");
    end

    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              we_pulse;
    logic              clr_pulse;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] clr_idx_n;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [BITS-1:0]   mem_wdata;
    logic [BITS-1:0]   mem [DEPTH];
    logic [BITS-1:0]   rd_word;

    logic [REFRESH_W-1:0] scan_cnt;
    logic [REFRESH_W:0]   scan_inc;
    logic [1:0]           digit;
    logic [3:0]           nibble;
    logic [AN_W-1:0]      an_v;
    logic                 busy_v;

    // Top switch selects which address register follows the lower switches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr <= '0;
            rd_addr <= '0;
        end else if (bus.addr_in[ADDR_W]) begin
            rd_addr <= bus.addr_in[ADDR_W-1:0];
        end else begin
            wr_addr <= bus.addr_in[ADDR_W-1:0];
        end
    end

    debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_db_we (
        .clk   (clk),
        .reset (reset),
        .in    (bus.we_btn),
        .out   (we_pulse)
    );

    debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk   (clk),
        .reset (reset),
        .in    (bus.clr_btn),
        .out   (clr_pulse)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            clr_idx <= '0;
        end else begin
            state   <= state_n;
            clr_idx <= clr_idx_n;
        end
    end

    always_comb begin
        state_n   = state;
        clr_idx_n = clr_idx;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = bus.data_w;
        unique case (state)
            IDLE: begin
                // Clear wins over a coincident write; the write is dropped.
                if (clr_pulse) begin
                    state_n   = CLEAR;
                    clr_idx_n = '0;
                end else if (we_pulse) begin
                    mem_we = 1'b1;
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx;
                mem_wdata = '0;
                clr_idx_n = clr_idx + 1'b1;
                if (clr_idx == '1) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    // Array deliberately has no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_word = mem[rd_addr];
    assign busy_v  = (state == CLEAR);

    assign scan_inc = {1'b0, scan_cnt} + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
        end else if (scan_inc == SCAN_LIMIT) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_inc[REFRESH_W-1:0];
        end
    end

    assign digit = scan_cnt[REFRESH_W-1 -: 2];

    always_comb begin
        nibble = '0;
        an_v   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit == 2'(i)) begin
                nibble = rd_word[4*i +: 4];
                an_v[i] = busy_v;
            end
        end
    end

    assign bus.an   = an_v;
    assign bus.sseg = busy_v ? SSEG_BLANK : hex2sseg(nibble);
    assign bus.busy = busy_v;

endmodule
